// File: rtl/ln_pkg.sv
// rtl/ln_pkg.sv - shared types and sizing for the layer-1 output skid stage
package ln_pkg;

  localparam int LN_L1_NEURONS = 12;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/ln_beat_counter.sv
// rtl/ln_beat_counter.sv - wrapping beat counter with synchronous clear (clear wins over increment)
module ln_beat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/layer1_output_skid_stage.sv
// rtl/layer1_output_skid_stage.sv - 2-entry registered skid buffer between neuron layers 1 and 2
// Optional beat counter port/logic enabled by defining LN_SKID_STATS_EN.
import ln_pkg::*;

module layer1_output_skid_stage #(
  parameter int WIDTH = LN_L1_NEURONS,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
`ifdef LN_SKID_STATS_EN
  output logic [CNT_W-1:0] beat_cnt,
`endif
  output logic [WIDTH-1:0] m_data
);

  if (WIDTH < 1 || CNT_W < 2) begin : g_param_check
    $error("layer1_output_skid_stage: WIDTH must be >= 1 and CNT_W >= 2");
  end

  skid_state_t      state_q, state_d;
  logic             s_ready_q, m_valid_q;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             in_fire, out_fire;
  logic             load_main_in, load_main_skid, load_skid;

  assign in_fire  = s_valid & s_ready_q;
  assign out_fire = m_valid_q & m_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && !out_fire) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (!in_fire && out_fire) begin
          state_d = EMPTY;
        end else if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush beats any same-cycle load; a same-cycle out-fire has still happened.
    if (clr) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Handshake outputs are flopped from the next state so m_ready never reaches s_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != FULL);
      m_valid_q <= (state_d != EMPTY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= s_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= s_data;
      end
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = main_q;

`ifdef LN_SKID_STATS_EN
  ln_beat_counter #(
    .CNT_W (CNT_W)
  ) u_beat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (out_fire),
    .count (beat_cnt)
  );
`endif

endmodule

// File: tb/tb_layer1_output_skid_stage.sv
// tb/tb_layer1_output_skid_stage.sv - directed plus queue-model checking of the layer-1 skid stage
module tb_layer1_output_skid_stage;

  localparam int WIDTH = 12;
`ifdef LN_SKID_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
`ifdef LN_SKID_STATS_EN
  logic [CNT_W-1:0] beat_cnt;
`endif

  int checks = 0;
  int failures = 0;

  layer1_output_skid_stage #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
`ifdef LN_SKID_STATS_EN
    .beat_cnt (beat_cnt),
`endif
    .m_data   (m_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two words plus a modular beat count.
  logic [WIDTH-1:0] mq[$];
  int unsigned      mcnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mcnt = 0;
    end else begin
      bit inf, outf;
      inf  = s_valid && (mq.size() < 2);
      outf = (mq.size() > 0) && m_ready;
      if (outf) mcnt = (mcnt + 1) % (1 << CNT_W);
      if (clr) begin
        mq.delete();
        mcnt = 0;
      end else begin
        if (outf) void'(mq.pop_front());
        if (inf) mq.push_back(s_data);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_m_valid", {31'd0, m_valid}, {31'd0, mq.size() > 0});
      chk("model_s_ready", {31'd0, s_ready}, {31'd0, mq.size() < 2});
      if (mq.size() > 0) chk("model_m_data", 32'(m_data), 32'(mq[0]));
`ifdef LN_SKID_STATS_EN
      chk("model_beat_cnt", 32'(beat_cnt), mcnt);
`endif
    end
  end

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic mr, input logic c);
    s_valid = v;
    s_data  = d;
    m_ready = mr;
    clr     = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    rst_n = 1'b1;
    chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
    chk("reset_s_ready", {31'd0, s_ready}, 32'd1);
    chk("reset_m_data", 32'(m_data), 32'h0);
`ifdef LN_SKID_STATS_EN
    chk("reset_beat_cnt", 32'(beat_cnt), 32'd0);
`endif

    // Streaming with no back-pressure: one-cycle latency, no bubbles.
    step(1, 12'hA5C, 1, 0);
    chk("stream0_data", 32'(m_data), 32'hA5C);
    chk("stream0_valid", {31'd0, m_valid}, 32'd1);
    step(1, 12'h3F0, 1, 0);
    chk("stream1_data", 32'(m_data), 32'h3F0);
    step(1, 12'h001, 1, 0);
    chk("stream2_data", 32'(m_data), 32'h001);
    chk("stream2_ready", {31'd0, s_ready}, 32'd1);
    step(0, '0, 1, 0);
    chk("stream_drained", {31'd0, m_valid}, 32'd0);

    // Back-pressure fills the skid, then drains in order.
    step(1, 12'h111, 0, 0);
    chk("bp_one_ready", {31'd0, s_ready}, 32'd1);
    step(1, 12'h222, 0, 0);
    chk("bp_full_ready", {31'd0, s_ready}, 32'd0);
    chk("bp_full_data", 32'(m_data), 32'h111);
    step(1, 12'h333, 0, 0);
    chk("bp_hold_data", 32'(m_data), 32'h111);
    step(0, '0, 1, 0);
    chk("bp_drain1_data", 32'(m_data), 32'h222);
    chk("bp_drain1_ready", {31'd0, s_ready}, 32'd1);
    step(0, '0, 1, 0);
    chk("bp_drain2_valid", {31'd0, m_valid}, 32'd0);

    // Simultaneous in/out while holding one word.
    step(1, 12'h0AA, 0, 0);
    step(1, 12'h0BB, 1, 0);
    chk("simul_data", 32'(m_data), 32'h0BB);
    chk("simul_valid", {31'd0, m_valid}, 32'd1);
    chk("simul_ready", {31'd0, s_ready}, 32'd1);
    step(0, '0, 1, 0);

    // Flush from FULL discards the incoming word too.
    step(1, 12'h123, 0, 0);
    step(1, 12'h456, 0, 0);
    step(1, 12'h789, 0, 1);
    chk("flush_valid", {31'd0, m_valid}, 32'd0);
    chk("flush_ready", {31'd0, s_ready}, 32'd1);
    step(0, '0, 1, 0);
    chk("flush_no_ghost", {31'd0, m_valid}, 32'd0);

`ifdef LN_SKID_STATS_EN
    step(0, '0, 0, 1);
    chk("stats_clr0", 32'(beat_cnt), 32'd0);
    for (int i = 0; i < 5; i++) step(1, 12'(i + 1), 1, 0);
    step(0, '0, 1, 0);
    chk("stats_wrap", 32'(beat_cnt), 32'd1);
    step(0, '0, 0, 1);
    chk("stats_clr", 32'(beat_cnt), 32'd0);
`endif

    // Random traffic against the queue model.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset while FULL.
    step(1, 12'hAAA, 0, 0);
    step(1, 12'hBBB, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("async_rst_ready", {31'd0, s_ready}, 32'd1);
    chk("async_rst_data", 32'(m_data), 32'h0);
`ifdef LN_SKID_STATS_EN
    chk("async_rst_cnt", 32'(beat_cnt), 32'd0);
`endif
    #1 rst_n = 1'b1;
    step(0, '0, 1, 0);
    chk("post_rst_empty", {31'd0, m_valid}, 32'd0);
    step(1, 12'hC3C, 1, 0);
    chk("post_rst_data", 32'(m_data), 32'hC3C);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
